// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        SIGN,
        DONE
    } mdu_state_t;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [31:0] DIV_ZERO_RES = 32'hFFFF_FFFF;
    localparam logic [31:0] OVF_DIV_RES  = 32'h8000_0000;
    localparam logic [31:0] OVF_REM_RES  = 32'h0000_0000;
    localparam logic [31:0] OVF_DIVIDEND = 32'h8000_0000;
    localparam logic [31:0] OVF_DIVISOR  = 32'hFFFF_FFFF;

    localparam int ITER_CNT = 32;
    localparam int CNT_W    = $clog2(ITER_CNT);

endpackage

// File: rtl/mdu_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module mdu_div_step #(
    parameter int XLEN = 32
) (
    input  logic [XLEN:0]   rem_i,
    input  logic            dividendBit_i,
    input  logic [XLEN-1:0] divisor_i,
    output logic [XLEN:0]   rem_o,
    output logic            quotBit_o
);

    logic [XLEN+1:0] shifted;
    logic [XLEN+1:0] trial;

    // A borrow out of the trial subtraction means the divisor did not fit.
    assign shifted   = {rem_i, dividendBit_i};
    assign trial     = shifted - {2'b00, divisor_i};
    assign quotBit_o = ~trial[XLEN+1];
    assign rem_o     = quotBit_o ? trial[XLEN:0] : shifted[XLEN:0];

endmodule

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide unit with start/busy/done handshake.
// Optional MDU_FAST_MUL_EN: multiplies use a single-cycle 33x33 signed multiplier.
module mdu_iterative
    import mdu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      Funct3,
    input  logic [XLEN-1:0] SrcA,
    input  logic [XLEN-1:0] SrcB,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] Result
);

    mdu_state_t        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic              negRes_q, negRes_d;
    logic              special_q, special_d;
    logic [XLEN-1:0]   specRes_q, specRes_d;
    logic [XLEN-1:0]   operand_q, operand_d;
    logic [2*XLEN-1:0] acc_q, acc_d;
    logic [XLEN:0]     rem_q, rem_d;
    logic [XLEN-1:0]   result_q, result_d;
    logic              busy_q, done_q;

    logic            signedA, signedB, negA, negB, isDiv;
    logic            divZero, overflow, special, bypass;
    logic [XLEN-1:0] absA, absB, specRes, finalRes;
    logic [XLEN:0]   mulSum, stepRem;
    logic            stepQ;

    assign isDiv   = Funct3[2];
    assign signedA = (Funct3 == F3_MULH) || (Funct3 == F3_MULHSU) ||
                     (Funct3 == F3_DIV)  || (Funct3 == F3_REM);
    assign signedB = (Funct3 == F3_MULH) || (Funct3 == F3_DIV) || (Funct3 == F3_REM);
    assign negA    = signedA & SrcA[XLEN-1];
    assign negB    = signedB & SrcB[XLEN-1];
    assign absA    = negA ? -SrcA : SrcA;
    assign absB    = negB ? -SrcB : SrcB;

    assign divZero  = isDiv && (SrcB == '0);
    assign overflow = ((Funct3 == F3_DIV) || (Funct3 == F3_REM)) &&
                      (SrcA == OVF_DIVIDEND) && (SrcB == OVF_DIVISOR);
    assign special  = divZero | overflow;
    // Funct3[1] distinguishes REM/REMU from DIV/DIVU.
    assign specRes  = divZero ? (Funct3[1] ? SrcA : DIV_ZERO_RES)
                              : (Funct3[1] ? OVF_REM_RES : OVF_DIV_RES);

`ifdef MDU_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fastProd;
    assign fastProd = $signed({negA, SrcA}) * $signed({negB, SrcB});
    assign bypass   = special | ~isDiv;
`else
    assign bypass   = special;
`endif

    assign mulSum = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, operand_q} : {(XLEN+1){1'b0}});

    mdu_div_step #(.XLEN(XLEN)) u_div_step (
        .rem_i         (rem_q),
        .dividendBit_i (acc_q[XLEN-1]),
        .divisor_i     (operand_q),
        .rem_o         (stepRem),
        .quotBit_o     (stepQ)
    );

    // High-word negation of the 64-bit product: ~hi plus the carry out of -lo.
    always_comb begin
        finalRes = '0;
        if (special_q) begin
            finalRes = specRes_q;
        end else begin
            case (op_q)
                F3_MUL:
                    finalRes = acc_q[XLEN-1:0];
                F3_MULH, F3_MULHSU, F3_MULHU:
                    finalRes = negRes_q
                        ? (~acc_q[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, ~|acc_q[XLEN-1:0]})
                        : acc_q[2*XLEN-1:XLEN];
                F3_DIV, F3_DIVU:
                    finalRes = negRes_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
                default:
                    finalRes = negRes_q ? -rem_q[XLEN-1:0] : rem_q[XLEN-1:0];
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        negRes_d  = negRes_q;
        special_d = special_q;
        specRes_d = specRes_q;
        operand_d = operand_q;
        acc_d     = acc_q;
        rem_d     = rem_q;
        result_d  = result_q;

        if (kill) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_d   = bypass ? SIGN : CALC;
                        cnt_d     = '0;
                        op_d      = Funct3;
                        special_d = special;
                        specRes_d = specRes;
                        negRes_d  = (isDiv && Funct3[1]) ? negA : (negA ^ negB);
                        operand_d = isDiv ? absB : absA;
                        acc_d     = {{XLEN{1'b0}}, isDiv ? absA : absB};
                        rem_d     = '0;
`ifdef MDU_FAST_MUL_EN
                        if (!isDiv) begin
                            acc_d    = fastProd;
                            negRes_d = 1'b0;
                        end
`endif
                    end else begin
                        state_d = IDLE;
                    end
                end
                CALC: begin
                    cnt_d = cnt_q + 1'b1;
                    if (op_q[2]) begin
                        rem_d = stepRem;
                        acc_d = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-2:0], stepQ};
                    end else begin
                        acc_d = {mulSum, acc_q[XLEN-1:1]};
                    end
                    if (cnt_q == CNT_W'(ITER_CNT - 1)) begin
                        state_d = SIGN;
                    end
                end
                SIGN: begin
                    result_d = finalRes;
                    state_d  = DONE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            op_q      <= '0;
            negRes_q  <= 1'b0;
            special_q <= 1'b0;
            specRes_q <= '0;
            operand_q <= '0;
            acc_q     <= '0;
            rem_q     <= '0;
            result_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            negRes_q  <= negRes_d;
            special_q <= special_d;
            specRes_q <= specRes_d;
            operand_q <= operand_d;
            acc_q     <= acc_d;
            rem_q     <= rem_d;
            result_q  <= result_d;
            busy_q    <= (state_d == CALC) || (state_d == SIGN);
            done_q    <= (state_d == DONE);
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign Result = result_q;

endmodule

// File: doc/mdu_iterative.md
# mdu_iterative

Iterative RV32M multiply/divide unit in the execute stage, beside the main ALU. The decode path selects it for R-type instructions with Funct7 = 0000001. It receives Funct3 and the two register operands, and computes the M-extension result over multiple cycles. A start/busy/done handshake lets the hazard logic stall the pipeline until the result is written back.

## Interface
Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  request; operands and Funct3 are sampled on the rising edge where start=1 and the unit is idle
- kill  in  1  synchronous flush; aborts any operation in progress
- Funct3  in  3  M-extension operation select:
  - 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU
  - 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  XLEN  rs1 value (multiplicand / dividend)
- SrcB  in  XLEN  rs2 value (multiplier / divisor)
- busy  out  1  operation in progress; high in CALC and SIGN
- done  out  1  one-cycle pulse; Result is valid in this cycle
- Result  out  XLEN  last result; held until the next accepted start

## Operation
- States:
  - IDLE: waiting for start.
  - CALC: 32 iterations.
  - SIGN: sign correction and result select.
  - DONE: done=1.
- Transitions:
  - IDLE --start--> CALC; for the special cases below, IDLE --start--> SIGN.
  - CALC --count==31--> SIGN.
  - SIGN --> DONE.
  - DONE --start--> CALC or SIGN; DONE --no start--> IDLE.
- start in CALC or SIGN is ignored. The hazard unit stalls on (start | busy) so that no request is lost.
- Capture:
  - Magnitudes |SrcA| and |SrcB| are taken according to signedness: MULH, DIV and REM treat both operands as signed; MULHSU treats SrcA as signed and SrcB as unsigned; all others are unsigned.
  - The result sign is latched at capture.
- Multiply: shift-add radix-2 into a 64-bit accumulator, one multiplier bit per cycle.
  - MUL returns product[31:0].
  - MULH, MULHSU and MULHU return product[63:32] after two's-complement negation when the result sign is negative.
- Divide: restoring radix-2, one quotient bit per cycle, 33-bit partial remainder.
  - Quotient sign = signA XOR signB.
  - Remainder sign = signA.
- Special cases are detected at capture; they bypass CALC and go straight to SIGN:
  - Divisor zero: DIV/DIVU give 0xFFFFFFFF; REM/REMU give SrcA.
  - Signed overflow (SrcA = 0x80000000, SrcB = 0xFFFFFFFF, DIV or REM): DIV gives 0x80000000; REM gives 0.
- All arithmetic is modulo 2^XLEN. No exceptions or flags are raised.
- kill has priority over start and over every state transition:
  - Next state is IDLE and the iteration counter clears.
  - done is not asserted and Result is unchanged.
  - kill and start in the same cycle: the start is discarded.
- Reset (asynchronous, at any time, including mid-operation): state goes to IDLE, with busy=0, done=0, Result=0, counter=0 and accumulators=0.

## Timing
- Edge E0 samples start.
- Normal path: CALC iterations occur at E1..E32; E33 moves SIGN->DONE and registers Result. done is high in the cycle after E33, i.e. 34 cycles after E0.
- Special-case path: E0->SIGN, E1->DONE; done is high 2 cycles after E0.
- busy is a registered output. It rises after E0 and falls at the edge that enters DONE, so it is never high together with done.
- Back-to-back operation: start during the DONE cycle is accepted at that edge. done then drops, and the next done follows with the same latency.
- Result changes only on the edge that enters DONE.

## Configuration
- MDU_FAST_MUL_EN defined: MUL/MULH/MULHSU/MULHU use a single-cycle 33x33 signed multiplier at capture. They take the special-case path (IDLE->SIGN->DONE, latency 2). Divides are unchanged.
- MDU_FAST_MUL_EN undefined: all multiplies are iterative, with latency 34.

## Structure
- mdu_pkg:
  - State enum mdu_state_t {IDLE, CALC, SIGN, DONE}.
  - Funct3 localparams F3_MUL..F3_REMU.
  - Constants for the divide-by-zero and overflow results.
  - ITER_CNT = 32.
- One sub-module, mdu_div_step: combinational single restoring-divide step. Inputs are partial remainder, dividend bit and divisor; outputs are next remainder and quotient bit. The top-level module holds the FSM, counter, accumulators and sign logic.

## Test plan
- MUL SrcA=7, SrcB=0xFFFFFFFD -> Result=0xFFFFFFEB; done exactly 34 cycles after start (2 with MDU_FAST_MUL_EN); busy high in between.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULH same operands -> 0x00000000; MULHSU SrcA=0xFFFFFFFF, SrcB=2 -> 0xFFFFFFFF.
- DIV -7/2 -> 0xFFFFFFFD; REM -7/2 -> 0xFFFFFFFF; DIVU 100/7 -> 14; REMU 100/7 -> 2.
- DIVU 5/0 -> 0xFFFFFFFF and REM 5/0 -> 5, each with done 2 cycles after start. DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM of the same operands -> 0.
- kill asserted in the 10th CALC cycle -> IDLE next cycle, no done pulse, Result keeps its previous value; start asserted while busy -> ignored.
- rst_n deasserted mid-divide -> busy=0, done=0 and Result=0 immediately (without waiting for a clock edge); a new start after reset completes correctly.
